// File: rtl/img_sram_pkg.sv
// Types shared by the image SRAM clients: the SRAM request bundle, the 3x3 window
// type handed to the convolution core, and the window reader FSM states.
package img_sram_pkg;

    localparam int IMG_ADDR_W   = 14;
    localparam int IMG_MAX_COLS = 128;

    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [IMG_ADDR_W-1:0] addr;
        logic [7:0]            din;
    } img_sram_ctrl_t;

    typedef logic [0:2][0:2][7:0] win3_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } win_state_e;

endpackage

// File: rtl/img_line_buffer.sv
// Circular byte delay line of programmable length: dout is the byte written `len`
// shifts ago. Used to recover the pixel one image row above the incoming one.
module img_line_buffer
    import img_sram_pkg::*;
#(
    parameter int MAX_COLS = IMG_MAX_COLS
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       shift,
    input  logic [7:0] len,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam int PTR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    logic [7:0]       mem [MAX_COLS];
    logic [PTR_W-1:0] ptr;
    logic             wrap;

    assign wrap = (ptr == PTR_W'(len - 8'd1));
    assign dout = mem[ptr];

    // Storage holds no state that matters before it has been written, so it has no reset.
    always_ff @(posedge clk) begin
        if (shift) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (shift) begin
            ptr <= wrap ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/img_window_reader.sv
// Raster-scans the image SRAM and streams every interior 3x3 window to the conv core.
// Optional build macro IMG_WIN_LAST_EN adds the win_eol / win_eof row and frame markers.
module img_window_reader
    import img_sram_pkg::*;
#(
    parameter int MAX_COLS = IMG_MAX_COLS,
    parameter int ADDR_W   = IMG_ADDR_W
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [7:0]     nrows,
    input  logic [7:0]     ncols,
    output logic           busy,
    output img_sram_ctrl_t sram_ctrl,
    input  logic [7:0]     sram_dout_in,
    output logic           win_valid,
    input  logic           win_ready,
    output win3_t          win_data
`ifdef IMG_WIN_LAST_EN
    ,
    output logic           win_eol,
    output logic           win_eof
`endif
);

    win_state_e        state, next_state;
    logic [7:0]        rows_q, cols_q;
    logic [ADDR_W-1:0] rd_addr, last_addr;
    logic              rd_en, rd_pending;
    logic [7:0]        skid_q;
    logic              skid_valid;
    logic [7:0]        proc_r, proc_c;
    logic [7:0]        px, lb1_out, lb2_out;
    win3_t             win_q, win_next, out_data;
    logic              out_valid, out_last;
    logic              start, stall, last_read, proc_en, is_win, is_last_px, last_accept;

    assign start       = (state == ST_IDLE) && en && (nrows >= 8'd3) && (ncols >= 8'd3);
    assign stall       = out_valid && !win_ready;
    assign last_read   = (rd_addr == last_addr);
    // A pixel is consumed from the skid first; the skid only fills while the output is stalled.
    assign proc_en     = (skid_valid || rd_pending) && !stall;
    assign px          = skid_valid ? skid_q : sram_dout_in;
    assign is_win      = (proc_r >= 8'd2) && (proc_c >= 8'd2);
    assign is_last_px  = (proc_r == rows_q - 8'd1) && (proc_c == cols_q - 8'd1);
    assign last_accept = out_valid && win_ready && out_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start)                 next_state = ST_RUN;
            ST_RUN:   if (rd_en && last_read)    next_state = ST_DRAIN;
            ST_DRAIN: if (last_accept)           next_state = ST_IDLE;
            default:                             next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        rd_en = (state == ST_RUN) && !stall;
    end

    always_comb begin
        sram_ctrl      = '0;
        sram_ctrl.en   = rd_en;
        sram_ctrl.addr = IMG_ADDR_W'(rd_addr);
    end

    // Newest column enters on the right: rows r-2, r-1 from the line buffers, row r from SRAM.
    always_comb begin
        win_next = win_q;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                win_next[i][j] = win_q[i][j+1];
            end
        end
        win_next[0][2] = lb2_out;
        win_next[1][2] = lb1_out;
        win_next[2][2] = px;
    end

    img_line_buffer #(.MAX_COLS(MAX_COLS)) u_lb_row1 (
        .clk   (clk),
        .rstn  (rstn),
        .clear (start),
        .shift (proc_en),
        .len   (cols_q),
        .din   (px),
        .dout  (lb1_out)
    );

    img_line_buffer #(.MAX_COLS(MAX_COLS)) u_lb_row2 (
        .clk   (clk),
        .rstn  (rstn),
        .clear (start),
        .shift (proc_en),
        .len   (cols_q),
        .din   (lb1_out),
        .dout  (lb2_out)
    );

    // The frame size wraps to zero in ADDR_W bits for a full 128x128 image; minus one still lands on the last address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows_q     <= '0;
            cols_q     <= '0;
            last_addr  <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            skid_q     <= '0;
            skid_valid <= 1'b0;
            proc_r     <= '0;
            proc_c     <= '0;
            win_q      <= '0;
        end else if (start) begin
            rows_q     <= nrows;
            cols_q     <= ncols;
            last_addr  <= ADDR_W'(ADDR_W'(nrows) * ADDR_W'(ncols) - ADDR_W'(1));
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            skid_valid <= 1'b0;
            proc_r     <= '0;
            proc_c     <= '0;
        end else begin
            rd_pending <= rd_en;
            if (rd_en && !last_read) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
            if (proc_en) begin
                skid_valid <= 1'b0;
            end
            if (rd_pending && stall) begin
                skid_q     <= sram_dout_in;
                skid_valid <= 1'b1;
            end
            if (proc_en) begin
                win_q <= win_next;
                if (proc_c == cols_q - 8'd1) begin
                    proc_c <= '0;
                    proc_r <= proc_r + 8'd1;
                end else begin
                    proc_c <= proc_c + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && win_ready) begin
                out_valid <= 1'b0;
            end
            if (proc_en && is_win) begin
                out_valid <= 1'b1;
                out_data  <= win_next;
                out_last  <= is_last_px;
            end
        end
    end

    assign win_valid = out_valid;
    assign win_data  = out_data;

`ifdef IMG_WIN_LAST_EN
    logic eol_q, eof_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            eol_q <= 1'b0;
            eof_q <= 1'b0;
        end else if (proc_en && is_win) begin
            eol_q <= (proc_c == cols_q - 8'd1);
            eof_q <= is_last_px;
        end
    end

    assign win_eol = out_valid && eol_q;
    assign win_eof = out_valid && eof_q;
`endif

endmodule
